hazard_stall_ctrl: RTL

//  Pipeline sequencing controller for the 5-stage RISC-V core. Detects load-use hazards and

---
 rtl/hazard_stall_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch flushes and a full freeze
// while a variable-latency data-memory access is outstanding, with a timeout error trap.
module hazard_stall_ctrl #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] ID_Rs1_i,
    input  logic [REG_AW-1:0] ID_Rs2_i,
    input  logic [REG_AW-1:0] EX_Rd_i,
    input  logic              EX_MemRead_i,
    input  logic              Branch_taken_i,
    input  logic              mem_req_i,
    input  logic              mem_ack_i,
    output logic              PCWrite_o,
    output logic              Stall_o,
    output logic              NoOp_o,
    output logic              Flush_o,
    output logic              MemStall_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic              err_o
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t            state;
    state_t            nextState;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] nextWaitCnt;
    logic [CNT_W-1:0]  stallCnt;
    logic              memStall;
    logic              hazard;

    // State and wait-cycle registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= RUN;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
        end
    end

    // Next-state logic; an ack always wins over the timeout in the same cycle
    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        unique case (state)
            RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    nextState   = MEM_WAIT;
                    nextWaitCnt = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ack_i) begin
                    nextState   = RUN;
                    nextWaitCnt = '0;
                end else if (waitCnt == WAIT_W'(TIMEOUT - 1)) begin
                    nextState = ERR;
                end else begin
                    nextWaitCnt = waitCnt + WAIT_W'(1);
                end
            end
            ERR: nextState = ERR;
            default: begin
                nextState   = RUN;
                nextWaitCnt = '0;
            end
        endcase
    end

    assign memStall = ((state == RUN) && mem_req_i && !mem_ack_i)
                    || (state == MEM_WAIT) || (state == ERR);

    assign hazard = EX_MemRead_i && (EX_Rd_i != '0)
                 && ((EX_Rd_i == ID_Rs1_i) || (EX_Rd_i == ID_Rs2_i));

    // Pipeline controls, priority memstall > hazard > branch
    always_comb begin
        PCWrite_o  = 1'b1;
        Stall_o    = 1'b0;
        NoOp_o     = 1'b0;
        Flush_o    = 1'b0;
        MemStall_o = 1'b0;
        if (memStall) begin
            MemStall_o = 1'b1;
            PCWrite_o  = 1'b0;
            Stall_o    = 1'b1;
        end else if (hazard) begin
            PCWrite_o = 1'b0;
            Stall_o   = 1'b1;
            NoOp_o    = 1'b1;
        end else if (Branch_taken_i) begin
            Flush_o = 1'b1;
        end
    end

    // Saturating stalled-cycle counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stallCnt <= '0;
        end else if ((memStall || hazard) && (stallCnt != {CNT_W{1'b1}})) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stallCnt;
    assign err_o       = (state == ERR);

endmodule
